// File: rtl/serial_adder_pkg.sv
// Shared state encodings and decode helper for the bit-serial adder.
// Build option: SERIAL_ADDER_SUB_EN adds a subtract request input to serial_adder.
package serial_adder_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // The spare encoding 2'd3 is folded onto IDLE so a corrupted state self-recovers.
  function automatic logic [1:0] norm_state(input logic [1:0] s);
    return (s == SHIFT || s == DONE) ? s : IDLE;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational full adder built from two half-adder stages and an OR for carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1, hc1, hc2;

  assign hs1 = a ^ b;
  assign hc1 = a & b;
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell, WIDTH clocks per operation.
// Build option: SERIAL_ADDER_SUB_EN adds input sub (a - b via ~b and carry-in 1).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_a, shift_b;
  logic [WIDTH-2:0] psum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_s, bit_co;
  logic [WIDTH-1:0] psum_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  fa_cell u_fa (
    .a  (shift_a[0]),
    .b  (shift_b[0]),
    .ci (carry),
    .s  (bit_s),
    .co (bit_co)
  );

  // Partial sum fills from the MSB down; after WIDTH-1 shifts the new bit completes it.
  assign psum_next = {bit_s, psum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift_a <= '0;
      shift_b <= '0;
      psum    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (norm_state(state))
        SHIFT: begin
          psum    <= psum_next[WIDTH-1:1];
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          carry   <= bit_co;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            sum   <= psum_next;
            cout  <= bit_co;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: begin
          state <= IDLE;
          if (start) begin
            shift_a <= a;
            shift_b <= b_load;
            carry   <= c_load;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
      endcase
    end
  end

  assign busy = (norm_state(state) == SHIFT);
  assign done = (norm_state(state) == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected {cout,sum} queued at start, checked at done.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       clk_en = 1'b1;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub = 1'b0;
`endif
  logic [7:0] sum;
  logic       cout, busy, done;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  always #5 if (clk_en) clk = ~clk;

  // Drives one start pulse and queues the expected result; returns at the negedge after E0.
  task automatic drive_start(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                             input logic tsub);
    logic [8:0] e;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = tsub;
`endif
    e = tsub ? ({1'b0, ta} + {1'b0, ~tb_v} + 9'd1) : ({1'b0, ta} + {1'b0, tb_v} + {8'd0, tc});
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  task automatic wait_done(output int lat, output int busy_cnt, output bit got);
    lat = -1; busy_cnt = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1; lat = i;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int lat, bc; bit got; logic [8:0] e;
    #1;
    checks++; if (sum !== 8'h00) begin failures++; $display("FAIL por_sum got=%h want=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL por_cout got=%b want=0", cout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL por_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL por_done got=%b want=0", done); end
    @(negedge clk); rst = 1'b0;
    drive_start(8'hC3, 8'h7F, 1'b0, 1'b0);
    wait_done(lat, bc, got);
    checks++;
    if (!got) begin failures++; $display("FAIL rst_pre_done got=timeout want=done"); end
    else begin
      e = exp_q.pop_front();
      if ({cout, sum} !== e) begin failures++; $display("FAIL rst_pre_value got=%h want=%h", {cout, sum}, e); end
    end
    drive_start(8'h12, 8'h34, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    clk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    checks++; if (sum !== 8'h00) begin failures++; $display("FAIL rst_async_sum got=%h want=00", sum); end
    checks++; if (cout !== 1'b0) begin failures++; $display("FAIL rst_async_cout got=%b want=0", cout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_async_done got=%b want=0", done); end
    #10 clk_en = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add;
    logic [7:0] ta[7] = '{8'h35, 8'hFF, 8'hFF, 8'h00, 8'h80, 8'h5A, 8'h01};
    logic [7:0] tb_t[7] = '{8'h4A, 8'h01, 8'hFF, 8'h00, 8'h80, 8'hA5, 8'hFE};
    logic       tc[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int lat, bc; bit got; logic [8:0] e;
    for (int i = 0; i < 7; i++) begin
      drive_start(ta[i], tb_t[i], tc[i], 1'b0);
      wait_done(lat, bc, got);
      checks++;
      if (!got) begin failures++; $display("FAIL add%0d_done got=timeout want=done", i); continue; end
      e = exp_q.pop_front();
      checks++; if ({cout, sum} !== e) begin failures++; $display("FAIL add%0d_value got=%h want=%h", i, {cout, sum}, e); end
      checks++; if (lat != 8) begin failures++; $display("FAIL add%0d_latency got=%0d want=8", i, lat); end
      checks++; if (bc != 8) begin failures++; $display("FAIL add%0d_busy_cycles got=%0d want=8", i, bc); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add%0d_busy_with_done got=%b want=0", i, busy); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL add%0d_done_pulse got=%b want=0", i, done); end
      checks++; if ({cout, sum} !== e) begin failures++; $display("FAIL add%0d_hold got=%h want=%h", i, {cout, sum}, e); end
    end
  endtask

  task automatic test_start_busy;
    int ndone = 0; logic [8:0] e; logic [8:0] seen = '0;
    drive_start(8'h01, 8'h01, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin ndone++; seen = {cout, sum}; end
      checks++; if (busy && done) begin failures++; $display("FAIL busy_done_overlap got=11 want=not both"); end
      @(negedge clk);
    end
    checks++; if (ndone != 1) begin failures++; $display("FAIL busy_start_dones got=%0d want=1", ndone); end
    e = exp_q.pop_front();
    checks++; if (seen !== e) begin failures++; $display("FAIL busy_start_value got=%h want=%h", seen, e); end
  endtask

  task automatic test_reset_mid;
    int lat, bc; bit got; bit saw_done = 1'b0; logic [8:0] e;
    drive_start(8'h55, 8'h66, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk); rst = 1'b1;
    #1;
    exp_q.delete();
    checks++; if ({cout, sum, busy, done} !== 11'd0) begin failures++; $display("FAIL mid_rst_outputs got=%h want=000", {cout, sum, busy, done}); end
    repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
    rst = 1'b0;
    repeat (10) begin @(negedge clk); if (done) saw_done = 1'b1; end
    checks++; if (saw_done) begin failures++; $display("FAIL mid_rst_no_done got=done want=none"); end
    drive_start(8'h10, 8'h20, 1'b0, 1'b0);
    wait_done(lat, bc, got);
    checks++;
    if (!got) begin failures++; $display("FAIL mid_restart_done got=timeout want=done"); end
    else begin
      e = exp_q.pop_front();
      checks++; if ({cout, sum} !== e) begin failures++; $display("FAIL mid_restart_value got=%h want=%h", {cout, sum}, e); end
      checks++; if (lat != 8) begin failures++; $display("FAIL mid_restart_latency got=%0d want=8", lat); end
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    logic [7:0] ta[3] = '{8'h10, 8'h20, 8'h37};
    logic [7:0] tb_t[3] = '{8'h20, 8'h10, 8'h37};
    logic       ts[3] = '{1'b1, 1'b1, 1'b0};
    int lat, bc; bit got; logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_start(ta[i], tb_t[i], 1'b0, ts[i]);
      wait_done(lat, bc, got);
      checks++;
      if (!got) begin failures++; $display("FAIL sub%0d_done got=timeout want=done", i); continue; end
      e = exp_q.pop_front();
      checks++; if ({cout, sum} !== e) begin failures++; $display("FAIL sub%0d_value got=%h want=%h", i, {cout, sum}, e); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_start_busy();
    test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
